// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit_if
//  Purpose  : Bundles the control unit's datapath/memory-facing signals.
//             master = control unit side, slave = datapath/memory side.
//  Signals  : opcode_in  [OPCODE_WIDTH] opcode field from IR   (to CU)
//             mem_ready                 memory finished rd/wr  (to CU)
//             zero_flag / neg_flag      A == 0 / A[MSB]        (to CU)
//             mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, A_load,
//             sel_A[2], ula_op[2], halted, bus_error, illegal_op (from CU)
//  Revision : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
   parameter int OPCODE_WIDTH = 5
);
   logic [OPCODE_WIDTH-1:0] opcode_in;
   logic                    mem_ready;
   logic                    zero_flag;
   logic                    neg_flag;
   logic                    mem_rd;
   logic                    mem_wr;
   logic                    addr_sel;
   logic                    ir_load;
   logic                    pc_inc;
   logic                    pc_load;
   logic                    A_load;
   logic [1:0]              sel_A;
   logic [1:0]              ula_op;
   logic                    halted;
   logic                    bus_error;
   logic                    illegal_op;

   modport master (
      input  opcode_in, mem_ready, zero_flag, neg_flag,
      output mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, A_load,
             sel_A, ula_op, halted, bus_error, illegal_op
   );

   modport slave (
      output opcode_in, mem_ready, zero_flag, neg_flag,
      input  mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, A_load,
             sel_A, ula_op, halted, bus_error, illegal_op
   );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Multicycle FSM sequencer for the 11-bit accumulator datapath.
//             Decodes the IR opcode, drives the A-input mux select, A load,
//             ALU operation, PC/IR strobes and data-memory requests. Memory
//             waits are bounded by a timeout that halts with a bus error.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset (forces all outputs 0)
//             bus  - control_unit_if.master (see interface for signal list)
//  Params   : OPCODE_WIDTH (5)  opcode field width
//             MEM_TIMEOUT  (15) wait cycles tolerated before bus error (>=1)
//  Config   : CU_COND_BRANCH_EN - when defined, BZ/BN are decoded as
//             conditional branches; otherwise they decode as illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
   parameter int OPCODE_WIDTH = 5,
   parameter int MEM_TIMEOUT  = 15
) (
   input  wire logic         clk,
   input  wire logic         rst,
   control_unit_if.master    bus
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   localparam logic [OPCODE_WIDTH-1:0] OP_NOP = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_LD  = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_ST  = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(5);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(7);
   localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(8);
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(9);
`ifdef CU_COND_BRANCH_EN
   localparam logic [OPCODE_WIDTH-1:0] OP_BZ  = OPCODE_WIDTH'(10);
   localparam logic [OPCODE_WIDTH-1:0] OP_BN  = OPCODE_WIDTH'(11);
`endif

   localparam logic [1:0] SEL_MEM = 2'b00;
   localparam logic [1:0] SEL_EXT = 2'b01;
   localparam logic [1:0] SEL_ULA = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_MEM_RD = 3'd2,
      ST_MEM_WR = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             bus_err_q, bus_err_nxt;

   // Unregistered output values before the reset gate.
   logic       mem_rd_c, mem_wr_c, addr_sel_c, ir_load_c, pc_inc_c;
   logic       pc_load_c, a_load_c, illegal_c, halted_c;
   logic [1:0] sel_a_c, ula_op_c;

   logic       timeout;

`ifndef CU_COND_BRANCH_EN
   // Flags only matter for conditional branches.
   logic unused_flags;
   assign unused_flags = bus.zero_flag ^ bus.neg_flag;
`endif

   // Expiry only counts when memory is still not ready in this cycle,
   // so a late mem_ready on the last allowed cycle completes normally.
   assign timeout = !bus.mem_ready && (wait_cnt == CNT_MAX);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FETCH;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         bus_err_q <= bus_err_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      bus_err_nxt = bus_err_q;
      mem_rd_c    = 1'b0;
      mem_wr_c    = 1'b0;
      addr_sel_c  = 1'b0;
      ir_load_c   = 1'b0;
      pc_inc_c    = 1'b0;
      pc_load_c   = 1'b0;
      a_load_c    = 1'b0;
      illegal_c   = 1'b0;
      halted_c    = 1'b0;
      sel_a_c     = SEL_MEM;
      ula_op_c    = 2'b00;

      case (state)
         ST_FETCH: begin
            mem_rd_c = 1'b1;
            if (bus.mem_ready) begin
               ir_load_c = 1'b1;
               pc_inc_c  = 1'b1;
               state_nxt = ST_DECODE;
            end else if (timeout) begin
               bus_err_nxt = 1'b1;
               state_nxt   = ST_HALT;
            end
         end

         ST_DECODE: begin
            state_nxt = ST_FETCH;
            case (bus.opcode_in)
               OP_NOP: ;
               OP_HLT: state_nxt = ST_HALT;
               OP_LDI: begin
                  a_load_c = 1'b1;
                  sel_a_c  = SEL_EXT;
               end
               OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR:
                  state_nxt = ST_MEM_RD;
               OP_ST:  state_nxt = ST_MEM_WR;
               OP_JMP: pc_load_c = 1'b1;
`ifdef CU_COND_BRANCH_EN
               OP_BZ:  pc_load_c = bus.zero_flag;
               OP_BN:  pc_load_c = bus.neg_flag;
`endif
               default: illegal_c = 1'b1;
            endcase
         end

         ST_MEM_RD: begin
            mem_rd_c   = 1'b1;
            addr_sel_c = 1'b1;
            // IR is stable here, so the mux/ALU selects hold for the whole wait.
            if (bus.opcode_in != OP_LD) begin
               sel_a_c = SEL_ULA;
               case (bus.opcode_in)
                  OP_SUB:  ula_op_c = 2'b01;
                  OP_AND:  ula_op_c = 2'b10;
                  OP_OR:   ula_op_c = 2'b11;
                  default: ula_op_c = 2'b00;
               endcase
            end
            if (bus.mem_ready) begin
               a_load_c  = 1'b1;
               state_nxt = ST_FETCH;
            end else if (timeout) begin
               bus_err_nxt = 1'b1;
               state_nxt   = ST_HALT;
            end
         end

         ST_MEM_WR: begin
            mem_wr_c   = 1'b1;
            addr_sel_c = 1'b1;
            if (bus.mem_ready) begin
               state_nxt = ST_FETCH;
            end else if (timeout) begin
               bus_err_nxt = 1'b1;
               state_nxt   = ST_HALT;
            end
         end

         ST_HALT: halted_c = 1'b1;

         default: state_nxt = ST_FETCH;
      endcase

      // Wait states only loop on themselves while memory is not ready, so
      // a self-loop means "count one more wait"; any transition restarts.
      if ((state_nxt == state) &&
          ((state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR)))
         wait_cnt_nxt = wait_cnt + CNT_W'(1);
      else
         wait_cnt_nxt = '0;
   end

   // ------------------------------------------------------------------
   // Output gate: everything is held low during reset, which also drops
   // an in-flight request and suppresses a completing A_load.
   // ------------------------------------------------------------------
   always_comb begin
      if (rst) begin
         bus.mem_rd     = 1'b0;
         bus.mem_wr     = 1'b0;
         bus.addr_sel   = 1'b0;
         bus.ir_load    = 1'b0;
         bus.pc_inc     = 1'b0;
         bus.pc_load    = 1'b0;
         bus.A_load     = 1'b0;
         bus.sel_A      = 2'b00;
         bus.ula_op     = 2'b00;
         bus.halted     = 1'b0;
         bus.bus_error  = 1'b0;
         bus.illegal_op = 1'b0;
      end else begin
         bus.mem_rd     = mem_rd_c;
         bus.mem_wr     = mem_wr_c;
         bus.addr_sel   = addr_sel_c;
         bus.ir_load    = ir_load_c;
         bus.pc_inc     = pc_inc_c;
         bus.pc_load    = pc_load_c;
         bus.A_load     = a_load_c;
         bus.sel_A      = sel_a_c;
         bus.ula_op     = ula_op_c;
         bus.halted     = halted_c;
         bus.bus_error  = bus_err_q;
         bus.illegal_op = illegal_c;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Self-checking bench for control_unit. Each instruction is
//             played out cycle by cycle from its instruction-level timing
//             (fetch waits, decode, memory waits) and every cycle's full
//             output vector is compared against the expected one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   control_unit_if #(.OPCODE_WIDTH(5)) bus ();

   control_unit #(
      .OPCODE_WIDTH (5),
      .MEM_TIMEOUT  (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // {mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, A_load,
   //  sel_A[1:0], ula_op[1:0], halted, bus_error, illegal_op}
   function automatic logic [13:0] observed();
      return {bus.mem_rd, bus.mem_wr, bus.addr_sel, bus.ir_load, bus.pc_inc,
              bus.pc_load, bus.A_load, bus.sel_A, bus.ula_op, bus.halted,
              bus.bus_error, bus.illegal_op};
   endfunction

   function automatic logic [13:0] mk(input bit rd, input bit wr, input bit as,
                                      input bit irl, input bit pci, input bit pcl,
                                      input bit al, input bit [1:0] sa,
                                      input bit [1:0] uo, input bit h,
                                      input bit be, input bit il);
      return {rd, wr, as, irl, pci, pcl, al, sa, uo, h, be, il};
   endfunction

   // One clock cycle: inputs already driven, compare mid-cycle, advance.
   task automatic chk(input string tag, input logic [13:0] exp);
      logic [13:0] obs;
      @(negedge clk);
      obs = observed();
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode_in = 5'($urandom);
      chk("reset_c0", '0);
      chk("reset_c1", '0);
      rst = 1'b0;
   endtask

   // Instruction-level reference: fetch with wf wait cycles, decode, then
   // an optional memory phase with wm wait cycles (or an expiring wait).
   task automatic run_instr(input logic [4:0] op, input int wf, input int wm,
                            input bit zf, input bit nf, input bit expire);
      logic [13:0] e;
      bit          is_rd, is_wr, branch_en;
      bit [1:0]    sa, uo;
`ifdef CU_COND_BRANCH_EN
      branch_en = 1'b1;
`else
      branch_en = 1'b0;
`endif
      bus.zero_flag = zf;
      bus.neg_flag  = nf;
      bus.opcode_in = 5'($urandom);   // IR still holds the previous word
      for (int i = 0; i < wf; i++) begin
         bus.mem_ready = 1'b0;
         chk("fetch_wait", mk(1,0,0,0,0,0,0,2'b00,2'b00,0,0,0));
      end
      bus.mem_ready = 1'b1;
      chk("fetch_done", mk(1,0,0,1,1,0,0,2'b00,2'b00,0,0,0));

      bus.opcode_in = op;
      bus.mem_ready = 1'($urandom_range(0, 1));
      is_rd = (op == 5'd2) || (op >= 5'd5 && op <= 5'd8);
      is_wr = (op == 5'd4);
      if (op == 5'd3)                         e = mk(0,0,0,0,0,0,1,2'b01,2'b00,0,0,0);
      else if (op == 5'd9)                    e = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,0,0);
      else if (op == 5'd10 && branch_en)      e = mk(0,0,0,0,0,zf,0,2'b00,2'b00,0,0,0);
      else if (op == 5'd11 && branch_en)      e = mk(0,0,0,0,0,nf,0,2'b00,2'b00,0,0,0);
      else if (op <= 5'd9)                    e = '0;
      else                                    e = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1);
      chk("decode", e);

      if (is_rd || is_wr) begin
         sa = (op == 5'd2 || is_wr) ? 2'b00 : 2'b10;
         uo = is_rd && op != 5'd2 ? 2'(op - 5'd5) : 2'b00;
         for (int i = 0; i < (expire ? TIMEOUT + 1 : wm); i++) begin
            bus.mem_ready = 1'b0;
            chk(is_rd ? "memrd_wait" : "memwr_wait",
                mk(is_rd, is_wr, 1, 0,0,0,0, sa, uo, 0,0,0));
         end
         if (expire) begin
            for (int i = 0; i < 4; i++) begin
               bus.mem_ready = 1'($urandom_range(0, 1));
               chk("bus_error_halt", mk(0,0,0,0,0,0,0,2'b00,2'b00,1,1,0));
            end
            do_reset();
         end else begin
            bus.mem_ready = 1'b1;
            chk(is_rd ? "memrd_done" : "memwr_done",
                mk(is_rd, is_wr, 1, 0,0,0, is_rd, sa, uo, 0,0,0));
         end
      end else if (op == 5'd1) begin
         for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.opcode_in = 5'($urandom);
            chk("halted", mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,0));
         end
         do_reset();
      end
   endtask

   initial begin
      bus.opcode_in = '0;
      bus.mem_ready = 1'b1;
      bus.zero_flag = 1'b0;
      bus.neg_flag  = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Directed steps
      run_instr(5'd3,  0, 0, 0, 0, 0);          // LDI, zero wait
      run_instr(5'd6,  0, 3, 0, 0, 0);          // SUB, 3 wait cycles
      run_instr(5'd0, TIMEOUT, 0, 0, 0, 0);     // ready on last allowed fetch cycle
      run_instr(5'd2,  1, TIMEOUT, 0, 0, 0);    // ready on last allowed read cycle
      run_instr(5'd31, 0, 0, 0, 0, 0);          // illegal opcode
      run_instr(5'd10, 0, 0, 1, 0, 0);          // BZ with zero_flag set
      run_instr(5'd11, 0, 0, 0, 1, 0);          // BN with neg_flag set
      run_instr(5'd9,  2, 0, 0, 0, 0);          // JMP
      run_instr(5'd4,  0, 0, 0, 0, 1);          // ST, memory never ready
      run_instr(5'd7,  0, 0, 0, 0, 1);          // AND, memory never ready
      run_instr(5'd1,  0, 0, 0, 0, 0);          // HLT

      // Reset in the middle of a memory read: request drops, no A_load.
      bus.opcode_in = 5'($urandom);
      bus.mem_ready = 1'b1;
      chk("abort_fetch", mk(1,0,0,1,1,0,0,2'b00,2'b00,0,0,0));
      bus.opcode_in = 5'd2;
      chk("abort_decode", '0);
      bus.mem_ready = 1'b0;
      chk("abort_wait", mk(1,0,1,0,0,0,0,2'b00,2'b00,0,0,0));
      bus.mem_ready = 1'b1;
      rst = 1'b1;
      chk("abort_rst", '0);
      rst = 1'b0;
      run_instr(5'd5, 0, 0, 0, 0, 0);

      // Randomised instruction stream
      for (int n = 0; n < 60; n++) begin
         run_instr(5'($urandom_range(0, 31)), $urandom_range(0, 4),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
`default_nettype wire
